// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the FP32 add scheduler.
package fp_add_sched_pkg;

   localparam int FP32_W = 32;

   localparam logic ID_REQ_1 = 1'b0;
   localparam logic ID_REQ_2 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/fp_add_sched_arb.sv
// rr_arb_2: combinational two-way round-robin winner select.
module rr_arb_2
   import fp_add_sched_pkg::*;
(
   input  logic       valid_1,
   input  logic       valid_2,
   input  logic       prio,
   output logic [1:0] grant,
   output logic       win_id
);

   always_comb begin
      grant  = 2'b00;
      win_id = ID_REQ_1;
      if (valid_1 && valid_2) begin
         if (prio) begin
            grant  = 2'b10;
            win_id = ID_REQ_2;
         end else begin
            grant  = 2'b01;
         end
      end else if (valid_1) begin
         grant  = 2'b01;
      end else if (valid_2) begin
         grant  = 2'b10;
         win_id = ID_REQ_2;
      end
   end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one multi-cycle FP32 add datapath between two requesters.
// Optional special-case bypass enabled by defining FP_ADD_SCHED_BYPASS_EN.
//
// state | meaning
// IDLE  | arbitrating, ready offered to the winner
// RUN   | operands held on datapath, latency counter running
// RESP  | result held on response channel until consumed
module fp_add_sched
   import fp_add_sched_pkg::*;
#(
   parameter int DP_LAT = 3,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_1_valid,
   output logic              req_1_ready,
   input  logic [FP32_W-1:0] req_1_op_1,
   input  logic [FP32_W-1:0] req_1_op_2,
   input  logic              req_2_valid,
   output logic              req_2_ready,
   input  logic [FP32_W-1:0] req_2_op_1,
   input  logic [FP32_W-1:0] req_2_op_2,
   output logic [FP32_W-1:0] dp_op_1,
   output logic [FP32_W-1:0] dp_op_2,
   output logic              dp_start,
   input  logic              dp_legal,
   input  logic [FP32_W-1:0] dp_res,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [FP32_W-1:0] rsp_res,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DP_LAT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [FP32_W-1:0] op_1_q, op_1_nxt;
   logic [FP32_W-1:0] op_2_q, op_2_nxt;
   logic [FP32_W-1:0] res_q, res_nxt;
   logic              id_q, id_nxt;
   logic              prio, prio_nxt;
   logic [1:0]        grant;
   logic              win_id;
   logic              first_run;
   logic              bypass;

   rr_arb_2 u_arb (
      .valid_1 (req_1_valid),
      .valid_2 (req_2_valid),
      .prio    (prio),
      .grant   (grant),
      .win_id  (win_id)
   );

`ifdef FP_ADD_SCHED_BYPASS_EN
   assign bypass = first_run && !dp_legal;
`else
   logic unused_dp_legal;
   assign unused_dp_legal = dp_legal;
   assign bypass          = 1'b0;
`endif

   // cnt only ever counts down from CNT_LOAD, so the load value marks RUN's first cycle
   assign first_run = (state == RUN) && (cnt == CNT_LOAD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op_1_q <= '0;
         op_2_q <= '0;
         res_q  <= '0;
         id_q   <= ID_REQ_1;
         prio   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         op_1_q <= op_1_nxt;
         op_2_q <= op_2_nxt;
         res_q  <= res_nxt;
         id_q   <= id_nxt;
         prio   <= prio_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      op_1_nxt    = op_1_q;
      op_2_nxt    = op_2_q;
      res_nxt     = res_q;
      id_nxt      = id_q;
      prio_nxt    = prio;
      req_1_ready = 1'b0;
      req_2_ready = 1'b0;
      dp_start    = 1'b0;
      rsp_valid   = 1'b0;
      case (state)
         IDLE: begin
            req_1_ready = grant[0];
            req_2_ready = grant[1];
            if (|grant) begin
               op_1_nxt  = (win_id == ID_REQ_2) ? req_2_op_1 : req_1_op_1;
               op_2_nxt  = (win_id == ID_REQ_2) ? req_2_op_2 : req_1_op_2;
               id_nxt    = win_id;
               cnt_nxt   = CNT_LOAD;
               state_nxt = RUN;
            end
         end
         RUN: begin
            dp_start = first_run;
            if (cnt == '0 || bypass) begin
               res_nxt   = dp_res;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               prio_nxt  = ~id_q;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dp_op_1 = op_1_q;
   assign dp_op_2 = op_2_q;
   assign rsp_res = res_q;
   assign rsp_id  = id_q;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed self-checking bench for fp_add_sched with a small latency-accurate datapath model.
module tb_fp_add_sched;

   localparam int DP_LAT = 3;
`ifdef FP_ADD_SCHED_BYPASS_EN
   localparam int BYP_LAT = 1;
`else
   localparam int BYP_LAT = DP_LAT;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_1_valid = 1'b0, req_2_valid = 1'b0;
   logic        req_1_ready, req_2_ready;
   logic [31:0] req_1_op_1 = '0, req_1_op_2 = '0, req_2_op_1 = '0, req_2_op_2 = '0;
   logic [31:0] dp_op_1, dp_op_2, dp_res, rsp_res;
   logic        dp_start, dp_legal, rsp_valid, rsp_id, busy;
   logic        rsp_ready = 1'b0;
   logic [1:0]  lat_cnt = 2'd0;
   int          pass_cnt = 0, total_cnt = 0, cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   fp_add_sched #(.DP_LAT(DP_LAT), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_1_valid(req_1_valid), .req_1_ready(req_1_ready),
      .req_1_op_1(req_1_op_1), .req_1_op_2(req_1_op_2),
      .req_2_valid(req_2_valid), .req_2_ready(req_2_ready),
      .req_2_op_1(req_2_op_1), .req_2_op_2(req_2_op_2),
      .dp_op_1(dp_op_1), .dp_op_2(dp_op_2), .dp_start(dp_start),
      .dp_legal(dp_legal), .dp_res(dp_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_res(rsp_res), .busy(busy)
   );

   // Datapath model: result only becomes valid DP_LAT cycles after dp_start,
   // special cases (NaN/inf exponent) are answered immediately.
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a + b;
   endfunction

   always @(posedge clk) begin
      if (dp_start) lat_cnt <= 2'd1;
      else if (lat_cnt != 2'd0 && lat_cnt != 2'd3) lat_cnt <= lat_cnt + 2'd1;
   end

   assign dp_legal = !(dp_op_1[30:23] == 8'hFF || dp_op_2[30:23] == 8'hFF);
   assign dp_res   = !dp_legal ? 32'h7FC0_0000 :
                     (lat_cnt >= 2'd2) ? model_add(dp_op_1, dp_op_2) : 32'hDEAD_BEEF;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 20) begin
         cyc();
         n++;
      end
   endtask

   task automatic do_reset();
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
      rsp_ready   = 1'b0;
      rst_n       = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
      rst_n = 1'b0;
      cyc();
      cyc();
      total_cnt++;
      if ({busy, dp_start, rsp_valid, rsp_id, req_1_ready, req_2_ready} !== 6'b0)
         $display("FAIL reset_ctrl: got %b want 000000",
                  {busy, dp_start, rsp_valid, rsp_id, req_1_ready, req_2_ready});
      else pass_cnt++;
      total_cnt++;
      if (dp_op_1 !== 32'h0 || dp_op_2 !== 32'h0 || rsp_res !== 32'h0)
         $display("FAIL reset_data: got %h %h %h want all 0", dp_op_1, dp_op_2, rsp_res);
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single();
      int n, starts;
      do_reset();
      req_1_op_1 = 32'h3F80_0000;
      req_1_op_2 = 32'h4000_0000;
      req_1_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if ({req_2_ready, req_1_ready} !== 2'b01)
         $display("FAIL single_ready: got %b want 01", {req_2_ready, req_1_ready});
      else pass_cnt++;
      cyc();
      req_1_valid = 1'b0;
      #1;
      total_cnt++;
      if (dp_start !== 1'b1 || req_1_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL single_start: got start=%b ready=%b busy=%b want 1 0 1",
                  dp_start, req_1_ready, busy);
      else pass_cnt++;
      total_cnt++;
      if (dp_op_1 !== 32'h3F80_0000 || dp_op_2 !== 32'h4000_0000)
         $display("FAIL single_ops: got %h %h want 3f800000 40000000", dp_op_1, dp_op_2);
      else pass_cnt++;
      starts = 1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         cyc();
         n++;
         if (dp_start) starts++;
      end
      total_cnt++;
      if (n !== DP_LAT) $display("FAIL single_latency: got %0d want %0d", n, DP_LAT);
      else pass_cnt++;
      total_cnt++;
      if (starts !== 1) $display("FAIL single_start_pulses: got %0d want 1", starts);
      else pass_cnt++;
      total_cnt++;
      if (rsp_res !== 32'h4040_0000 || rsp_id !== 1'b0)
         $display("FAIL single_rsp: got %h id=%b want 40400000 id=0", rsp_res, rsp_id);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp_valid, busy);
      else pass_cnt++;
   endtask

   task automatic test_tie();
      int n, last_acc;
      logic exp_id;
      do_reset();
      req_1_op_1 = 32'h3F80_0000;
      req_1_op_2 = 32'h4000_0000;
      req_2_op_1 = 32'h0000_0005;
      req_2_op_2 = 32'h0000_0007;
      req_1_valid = 1'b1;
      req_2_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      last_acc = 0;
      for (int k = 0; k < 4; k++) begin
         exp_id = k[0];
         n = 0;
         while (!(req_1_ready || req_2_ready) && n < 20) begin
            cyc();
            n++;
         end
         total_cnt++;
         if ({req_2_ready, req_1_ready} !== (exp_id ? 2'b10 : 2'b01))
            $display("FAIL tie_grant_%0d: got %b want %b", k, {req_2_ready, req_1_ready},
                     exp_id ? 2'b10 : 2'b01);
         else pass_cnt++;
         if (k > 0) begin
            total_cnt++;
            if (cyc_cnt - last_acc !== DP_LAT + 2)
               $display("FAIL tie_throughput_%0d: got %0d want %0d", k, cyc_cnt - last_acc,
                        DP_LAT + 2);
            else pass_cnt++;
         end
         last_acc = cyc_cnt;
         cyc();
         wait_rsp(n);
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
             rsp_res !== (exp_id ? 32'h0000_000C : 32'h4040_0000))
            $display("FAIL tie_rsp_%0d: got valid=%b id=%b res=%h want 1 %b %h", k, rsp_valid,
                     rsp_id, rsp_res, exp_id, exp_id ? 32'h0000_000C : 32'h4040_0000);
         else pass_cnt++;
         cyc();
      end
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      req_1_op_1 = 32'h0000_0010;
      req_1_op_2 = 32'h0000_0020;
      req_1_valid = 1'b1;
      rsp_ready = 1'b0;
      #1;
      cyc();
      req_2_valid = 1'b1;
      wait_rsp(n);
      total_cnt++;
      if (n !== DP_LAT) $display("FAIL bp_latency: got %0d want %0d", n, DP_LAT);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_res !== 32'h0000_0030 || rsp_id !== 1'b0 ||
             dp_op_1 !== 32'h0000_0010 || dp_op_2 !== 32'h0000_0020 ||
             req_1_ready !== 1'b0 || req_2_ready !== 1'b0)
            $display("FAIL bp_hold_%0d: got v=%b res=%h id=%b ops=%h/%h rdy=%b%b want 1 30 0 10/20 00",
                     i, rsp_valid, rsp_res, rsp_id, dp_op_1, dp_op_2, req_1_ready, req_2_ready);
         else pass_cnt++;
         cyc();
      end
      rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_res !== 32'h0000_0030)
         $display("FAIL bp_sixth: got v=%b res=%h want 1 00000030", rsp_valid, rsp_res);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (rsp_valid !== 1'b0 || {req_2_ready, req_1_ready} !== 2'b10)
         $display("FAIL bp_release: got v=%b rdy=%b want 0 10", rsp_valid,
                  {req_2_ready, req_1_ready});
      else pass_cnt++;
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int n, seen;
      do_reset();
      req_1_op_1 = 32'h0000_0001;
      req_1_op_2 = 32'h0000_0002;
      req_2_op_1 = 32'h0000_0005;
      req_2_op_2 = 32'h0000_0007;
      req_1_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      cyc();
      req_1_valid = 1'b0;
      wait_rsp(n);
      cyc();
      req_1_valid = 1'b1;
      req_2_valid = 1'b1;
      #1;
      total_cnt++;
      if ({req_2_ready, req_1_ready} !== 2'b10)
         $display("FAIL rmr_pre_grant: got %b want 10", {req_2_ready, req_1_ready});
      else pass_cnt++;
      cyc();
      cyc();
      rst_n = 1'b0;
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
      cyc();
      total_cnt++;
      if ({busy, dp_start, rsp_valid, rsp_id, req_1_ready, req_2_ready} !== 6'b0 ||
          dp_op_1 !== 32'h0 || dp_op_2 !== 32'h0 || rsp_res !== 32'h0)
         $display("FAIL rmr_cleared: got ctrl=%b ops=%h/%h res=%h want all 0",
                  {busy, dp_start, rsp_valid, rsp_id, req_1_ready, req_2_ready},
                  dp_op_1, dp_op_2, rsp_res);
      else pass_cnt++;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (rsp_valid) seen++;
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL rmr_no_rsp: got %0d responses want 0", seen);
      else pass_cnt++;
      req_1_valid = 1'b1;
      req_2_valid = 1'b1;
      #1;
      total_cnt++;
      if ({req_2_ready, req_1_ready} !== 2'b01)
         $display("FAIL rmr_tie_after: got %b want 01", {req_2_ready, req_1_ready});
      else pass_cnt++;
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
   endtask

   task automatic test_bypass();
      int n;
      do_reset();
      req_1_op_1 = 32'h7FC0_0000;
      req_1_op_2 = 32'h3F80_0000;
      req_1_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      cyc();
      req_1_valid = 1'b0;
      wait_rsp(n);
      total_cnt++;
      if (n !== BYP_LAT) $display("FAIL bypass_latency: got %0d want %0d", n, BYP_LAT);
      else pass_cnt++;
      total_cnt++;
      if (rsp_res !== 32'h7FC0_0000 || rsp_id !== 1'b0)
         $display("FAIL bypass_rsp: got %h id=%b want 7fc00000 id=0", rsp_res, rsp_id);
      else pass_cnt++;
      cyc();
      req_2_op_1 = 32'h0000_0005;
      req_2_op_2 = 32'h0000_0007;
      req_2_valid = 1'b1;
      #1;
      cyc();
      req_2_valid = 1'b0;
      wait_rsp(n);
      total_cnt++;
      if (n !== DP_LAT || rsp_res !== 32'h0000_000C || rsp_id !== 1'b1)
         $display("FAIL bypass_normal: got lat=%0d res=%h id=%b want %0d 0000000c 1",
                  n, rsp_res, rsp_id, DP_LAT);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_solo();
      int n;
      do_reset();
      req_2_op_1 = 32'h0000_0100;
      req_2_op_2 = 32'h0000_0200;
      req_2_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if ({req_2_ready, req_1_ready} !== 2'b10)
         $display("FAIL solo_grant: got %b want 10", {req_2_ready, req_1_ready});
      else pass_cnt++;
      cyc();
      req_2_valid = 1'b0;
      wait_rsp(n);
      total_cnt++;
      if (n !== DP_LAT || rsp_id !== 1'b1 || rsp_res !== 32'h0000_0300)
         $display("FAIL solo_rsp: got lat=%0d id=%b res=%h want %0d 1 00000300",
                  n, rsp_id, rsp_res, DP_LAT);
      else pass_cnt++;
      cyc();
      req_1_valid = 1'b1;
      req_2_valid = 1'b1;
      #1;
      total_cnt++;
      if ({req_2_ready, req_1_ready} !== 2'b01)
         $display("FAIL solo_prio_after: got %b want 01", {req_2_ready, req_1_ready});
      else pass_cnt++;
      req_1_valid = 1'b0;
      req_2_valid = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_reset_mid_run();
      test_bypass();
      test_solo();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
